// File: rtl/classifier_flow_aging.sv
// Background flow aging scanner: walks the flow etime table and requests deletion of idle flows.
// Optional counters are enabled with `define CLASSIFIER_FLOW_AGING_STATS_EN.
module classifier_flow_aging #(
    parameter int VALUE_DEPTH_NBITS = 4,
    parameter int EXP_TIME_NBITS    = 16,
    parameter int REAL_TIME_NBITS   = 32,
    parameter int FID_NBITS         = 16,
    parameter int INTERVAL_NBITS    = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         aging_en,
    input  logic [EXP_TIME_NBITS-1:0]    aging_timeout,
    input  logic [INTERVAL_NBITS-1:0]    scan_interval,
    input  logic [REAL_TIME_NBITS-1:0]   current_time,
    output logic                         flow_etime_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] flow_etime_raddr,
    input  logic                         flow_etime_ack,
    input  logic [EXP_TIME_NBITS-1:0]    flow_etime_rdata,
    output logic                         aging_valid,
    output logic [FID_NBITS-1:0]         aging_fid,
    input  logic                         aging_ready,
    output logic                         aging_busy
`ifdef CLASSIFIER_FLOW_AGING_STATS_EN
    ,
    output logic [31:0]                  aging_expired_cnt,
    output logic [31:0]                  aging_pass_cnt
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CMP  = 3'd3;
    localparam logic [2:0] ST_EMIT = 3'd4;
    localparam logic [2:0] ST_NEXT = 3'd5;

    localparam logic [VALUE_DEPTH_NBITS-1:0] ADDR_ZERO = {VALUE_DEPTH_NBITS{1'b0}};
    localparam logic [VALUE_DEPTH_NBITS-1:0] ADDR_LAST = {VALUE_DEPTH_NBITS{1'b1}};
    localparam logic [VALUE_DEPTH_NBITS-1:0] ADDR_ONE  = {{(VALUE_DEPTH_NBITS-1){1'b0}}, 1'b1};
    localparam logic [INTERVAL_NBITS-1:0]    ICNT_ZERO = {INTERVAL_NBITS{1'b0}};
    localparam logic [INTERVAL_NBITS-1:0]    ICNT_ONE  = {{(INTERVAL_NBITS-1){1'b0}}, 1'b1};
    localparam logic [EXP_TIME_NBITS-1:0]    ETIME_ZERO = {EXP_TIME_NBITS{1'b0}};

    logic [2:0]                   state_q, state_d;
    logic [INTERVAL_NBITS-1:0]    icnt_q, icnt_d;
    logic [VALUE_DEPTH_NBITS-1:0] addr_q, addr_d;
    logic [EXP_TIME_NBITS-1:0]    rdata_q, rdata_d;
    logic [EXP_TIME_NBITS-1:0]    now_q, now_d;
    logic                         rd_q, valid_q, busy_q;
    logic [VALUE_DEPTH_NBITS-1:0] raddr_q;
    logic [FID_NBITS-1:0]         fid_q;
    logic [EXP_TIME_NBITS-1:0]    age_s;
    logic                         expired_s;

    // Modular subtraction makes a timestamp wrap-around look like a small age.
    assign age_s     = now_q - rdata_q;
    assign expired_s = (rdata_q != ETIME_ZERO) && (age_s > aging_timeout);

    // Scan sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        now_d   = now_q;
        case (state_q)
            ST_IDLE: begin
                if (!aging_en) begin
                    icnt_d = ICNT_ZERO;
                end else if (icnt_q >= scan_interval) begin
                    icnt_d  = ICNT_ZERO;
                    state_d = ST_READ;
                end else begin
                    icnt_d = icnt_q + ICNT_ONE;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (flow_etime_ack) begin
                    rdata_d = flow_etime_rdata;
                    now_d   = current_time[REAL_TIME_NBITS-1 -: EXP_TIME_NBITS];
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CMP: begin
                if (expired_s) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_EMIT: begin
                if (aging_ready) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_NEXT: begin
                // A disable request takes effect only once the current entry is done.
                if ((addr_q == ADDR_LAST) || !aging_en) begin
                    addr_d  = ADDR_ZERO;
                    icnt_d  = ICNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, all decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            icnt_q  <= ICNT_ZERO;
            addr_q  <= ADDR_ZERO;
            rdata_q <= ETIME_ZERO;
            now_q   <= ETIME_ZERO;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            raddr_q <= ADDR_ZERO;
            fid_q   <= {FID_NBITS{1'b0}};
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            now_q   <= now_d;
            rd_q    <= (state_d == ST_READ);
            valid_q <= (state_d == ST_EMIT);
            busy_q  <= (state_d != ST_IDLE);
            raddr_q <= addr_d;
            fid_q   <= FID_NBITS'(addr_d);
        end
    end

    assign flow_etime_rd    = rd_q;
    assign flow_etime_raddr = raddr_q;
    assign aging_valid      = valid_q;
    assign aging_fid        = fid_q;
    assign aging_busy       = busy_q;

`ifdef CLASSIFIER_FLOW_AGING_STATS_EN
    logic [31:0] exp_cnt_q, pass_cnt_q;

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_cnt_q  <= 32'd0;
            pass_cnt_q <= 32'd0;
        end else begin
            if ((state_q == ST_EMIT) && aging_ready && (exp_cnt_q != 32'hFFFF_FFFF)) begin
                exp_cnt_q <= exp_cnt_q + 32'd1;
            end else begin
                exp_cnt_q <= exp_cnt_q;
            end
            if ((state_q == ST_NEXT) && (addr_q == ADDR_LAST) && (pass_cnt_q != 32'hFFFF_FFFF)) begin
                pass_cnt_q <= pass_cnt_q + 32'd1;
            end else begin
                pass_cnt_q <= pass_cnt_q;
            end
        end
    end

    assign aging_expired_cnt = exp_cnt_q;
    assign aging_pass_cnt    = pass_cnt_q;
`endif

endmodule

// File: tb/tb_classifier_flow_aging.sv
// Randomised and directed bench for classifier_flow_aging with an in-bench flow table and expiry model.
module tb_classifier_flow_aging;
    localparam int VD = 4;
    localparam int ET = 16;
    localparam int RT = 32;
    localparam int FN = 8;
    localparam int IN = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aging_en = 1'b0;
    logic [ET-1:0] aging_timeout = '0;
    logic [IN-1:0] scan_interval = '0;
    logic [RT-1:0] current_time = '0;
    logic          flow_etime_rd;
    logic [VD-1:0] flow_etime_raddr;
    logic          flow_etime_ack = 1'b0;
    logic [ET-1:0] flow_etime_rdata = '0;
    logic          aging_valid;
    logic [FN-1:0] aging_fid;
    logic          aging_ready = 1'b0;
    logic          aging_busy;
`ifdef CLASSIFIER_FLOW_AGING_STATS_EN
    logic [31:0]   aging_expired_cnt;
    logic [31:0]   aging_pass_cnt;
`endif

    classifier_flow_aging #(
        .VALUE_DEPTH_NBITS(VD), .EXP_TIME_NBITS(ET), .REAL_TIME_NBITS(RT),
        .FID_NBITS(FN), .INTERVAL_NBITS(IN)
    ) dut (
        .clk(clk), .rst(rst), .aging_en(aging_en), .aging_timeout(aging_timeout),
        .scan_interval(scan_interval), .current_time(current_time),
        .flow_etime_rd(flow_etime_rd), .flow_etime_raddr(flow_etime_raddr),
        .flow_etime_ack(flow_etime_ack), .flow_etime_rdata(flow_etime_rdata),
        .aging_valid(aging_valid), .aging_fid(aging_fid), .aging_ready(aging_ready),
        .aging_busy(aging_busy)
`ifdef CLASSIFIER_FLOW_AGING_STATS_EN
        , .aging_expired_cnt(aging_expired_cnt), .aging_pass_cnt(aging_pass_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [ET-1:0] mem [16];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0, rd_cnt = 0, hs_cnt = 0, fall_cyc = 0;
    int rd_cyc [4096];
    int rd_adr [4096];
    int hs_fid [1024];
    int exp_q [$];
    bit pend = 0;
    int pend_addr = 0, exp_addr = 0, last_rd_cyc = -100;
    int ready_mode = 1;
    bit time_run = 0, noise_en = 0;
    logic [31:0] ct_base = 32'h0, ct_off = 32'h0;
    int restart_req = 0, restart_seen = 0;
    bit prev_hold = 0, prev_busy = 0;
    int prev_fid = 0;

    function automatic void check(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endfunction

    // Flow table responder, expiry model and per-cycle output checks.
    always @(negedge clk) begin
        logic [ET-1:0] now16, age, rv;
        cyc++;
        if (time_run) ct_off = ct_off + (32'($urandom_range(0, 2)) << 16);
        else ct_off = 32'h0;
        current_time = ct_base + ct_off;
        if (rst) begin
            flow_etime_ack = 1'b0;
            pend = 0;
            exp_q.delete();
            exp_addr = 0;
            prev_hold = 0;
            prev_busy = 0;
            last_rd_cyc = -100;
            aging_ready = 1'b0;
        end else begin
            if (restart_req != restart_seen) begin
                exp_addr = 0;
                restart_seen = restart_req;
            end
            flow_etime_ack = pend | (noise_en && ($urandom_range(0, 3) == 0));
            if (pend) begin
                rv = mem[pend_addr];
                flow_etime_rdata = rv;
                now16 = current_time[RT-1 -: ET];
                age = now16 - rv;
                if (rv != 16'h0 && age > aging_timeout) exp_q.push_back(pend_addr);
            end else begin
                flow_etime_rdata = 16'($urandom);
            end
            pend = flow_etime_rd;
            if (flow_etime_rd) begin
                check(int'(flow_etime_raddr) == exp_addr, "rd_addr", flow_etime_raddr, exp_addr);
                check(cyc - last_rd_cyc >= 4, "rd_spacing", cyc - last_rd_cyc, 4);
                check(!aging_valid, "rd_during_emit", aging_valid, 0);
                rd_cyc[rd_cnt] = cyc;
                rd_adr[rd_cnt] = int'(flow_etime_raddr);
                rd_cnt++;
                last_rd_cyc = cyc;
                exp_addr = (exp_addr + 1) % 16;
                pend_addr = int'(flow_etime_raddr);
            end
            case (ready_mode)
                0: aging_ready = 1'b0;
                1: aging_ready = 1'b1;
                default: aging_ready = 1'($urandom_range(0, 1));
            endcase
            if (aging_valid && aging_ready) begin
                check(exp_q.size() != 0, "emit_expected", aging_fid, 0);
                if (exp_q.size() != 0) begin
                    check(int'(aging_fid) == exp_q[0], "emit_fid", aging_fid, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (hs_cnt < 1024) hs_fid[hs_cnt] = int'(aging_fid);
                hs_cnt++;
            end
            if (prev_hold) check(aging_valid && int'(aging_fid) == prev_fid, "valid_hold", aging_fid, prev_fid);
            prev_hold = aging_valid && !aging_ready;
            prev_fid = int'(aging_fid);
            if (prev_busy && !aging_busy) fall_cyc = cyc;
            prev_busy = aging_busy;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rd(input int target, input string name);
        int b = 0;
        while (rd_cnt < target && b < 3000) begin tick(); b++; end
        check(rd_cnt >= target, name, rd_cnt, target);
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while (aging_busy && b < 3000) begin tick(); b++; end
        check(!aging_busy, name, aging_busy, 0);
    endtask

    task automatic wait_valid(input string name);
        int b = 0;
        while (!aging_valid && b < 3000) begin tick(); b++; end
        check(aging_valid, name, aging_valid, 1);
    endtask

    task automatic run_pass(input int nreads, input string name);
        int r0 = rd_cnt;
        aging_en = 1'b1;
        wait_rd(r0 + nreads, name);
        aging_en = 1'b0;
        wait_idle(name);
        check(exp_q.size() == 0, "model_drained", exp_q.size(), 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    endtask

    task automatic single_expiry(input int a, input logic [ET-1:0] stamp, input logic [ET-1:0] now,
                                 input logic [ET-1:0] tmo, input int n_exp, input string name);
        int h0 = hs_cnt;
        clear_mem();
        mem[a] = stamp;
        ct_base = {now, 16'($urandom)};
        aging_timeout = tmo;
        run_pass(16, name);
        check(hs_cnt - h0 == n_exp, name, hs_cnt - h0, n_exp);
        if (n_exp != 0 && hs_cnt - h0 >= 1) check(hs_fid[h0] == a, name, hs_fid[h0], a);
    endtask

    initial begin
        int r0, h0, rb;
        clear_mem();
        repeat (3) tick();
        check(!aging_valid && !flow_etime_rd && !aging_busy, "reset_ctl", {aging_valid, flow_etime_rd, aging_busy}, 0);
        check(flow_etime_raddr == 4'h0 && aging_fid == 8'h0, "reset_addr", {flow_etime_raddr, aging_fid}, 0);
        rst = 1'b0;
        tick();
        check(!aging_busy, "idle_no_en", aging_busy, 0);

        // Basic pass over an empty table with a 10-clock interval.
        scan_interval = 24'd10;
        ct_base = 32'h1234_0000;
        r0 = rd_cnt;
        h0 = hs_cnt;
        aging_en = 1'b1;
        wait_rd(r0 + 17, "basic_reads");
        check(rd_adr[r0 + 15] == 15, "basic_last_addr", rd_adr[r0 + 15], 15);
        check(rd_adr[r0 + 16] == 0, "basic_wrap_addr", rd_adr[r0 + 16], 0);
        check(rd_cyc[r0 + 16] - rd_cyc[r0 + 15] == 15, "basic_interval", rd_cyc[r0 + 16] - rd_cyc[r0 + 15], 15);
        check(fall_cyc - rd_cyc[r0 + 15] == 4, "basic_busy_fall", fall_cyc - rd_cyc[r0 + 15], 4);
        aging_en = 1'b0;
        wait_idle("basic_stop");
        restart_req++;
        check(hs_cnt == h0, "basic_no_emit", hs_cnt - h0, 0);
        scan_interval = 24'd0;

        single_expiry(5, 16'h0100, 16'h0200, 16'h00FF, 1, "expiry");
        single_expiry(5, 16'h0100, 16'h0200, 16'h0100, 0, "expiry_strict");
        single_expiry(3, 16'hFFF0, 16'h0010, 16'h001F, 1, "wrap");
        single_expiry(3, 16'hFFF0, 16'h0010, 16'h0020, 0, "wrap_strict");

        // Backpressure: fid 2 must be held while no further reads issue.
        clear_mem();
        mem[2] = 16'h0100;
        mem[9] = 16'h0100;
        ct_base = 32'h0200_0000;
        aging_timeout = 16'h0010;
        ready_mode = 0;
        r0 = rd_cnt;
        h0 = hs_cnt;
        aging_en = 1'b1;
        wait_valid("bp_valid");
        rb = rd_cnt;
        repeat (20) begin
            tick();
            check(aging_valid && aging_fid == 8'd2, "bp_hold", {aging_valid, aging_fid}, {1'b1, 8'd2});
        end
        check(rd_cnt == rb, "bp_no_reads", rd_cnt - rb, 0);
        ready_mode = 1;
        wait_rd(r0 + 16, "bp_reads");
        aging_en = 1'b0;
        wait_idle("bp_stop");
        check(hs_cnt - h0 == 2, "bp_count", hs_cnt - h0, 2);
        check(hs_fid[h0] == 2 && hs_fid[h0 + 1] == 9, "bp_order", {hs_fid[h0], hs_fid[h0 + 1]}, {32'd2, 32'd9});

        // Disable while entry 7 is outstanding.
        clear_mem();
        mem[7] = 16'h0100;
        r0 = rd_cnt;
        h0 = hs_cnt;
        aging_en = 1'b1;
        wait_rd(r0 + 8, "dis_reads");
        tick();
        aging_en = 1'b0;
        wait_idle("dis_idle");
        check(rd_cnt - r0 == 8, "dis_read_count", rd_cnt - r0, 8);
        check(hs_cnt - h0 == 1 && hs_fid[h0] == 7, "dis_entry_done", hs_fid[h0], 7);
        restart_req++;
        clear_mem();
        r0 = rd_cnt;
        run_pass(16, "dis_restart");
        check(rd_adr[r0] == 0, "dis_restart_addr", rd_adr[r0], 0);

        // Reset while a request is pending.
        mem[4] = 16'h0100;
        ready_mode = 0;
        aging_en = 1'b1;
        wait_valid("rst_valid");
        rst = 1'b1;
        #1;
        check(!aging_valid && !aging_busy && !flow_etime_rd, "rst_abort", {aging_valid, aging_busy}, 0);
        aging_en = 1'b0;
        ready_mode = 1;
        tick();
        tick();
`ifdef CLASSIFIER_FLOW_AGING_STATS_EN
        check(aging_expired_cnt == 32'd0 && aging_pass_cnt == 32'd0, "stats_reset", aging_expired_cnt, 0);
`endif
        rst = 1'b0;
        clear_mem();
        r0 = rd_cnt;
        run_pass(16, "rst_restart");
        check(rd_adr[r0] == 0, "rst_restart_addr", rd_adr[r0], 0);

`ifdef CLASSIFIER_FLOW_AGING_STATS_EN
        begin
            logic [31:0] e0, p0;
            e0 = aging_expired_cnt;
            p0 = aging_pass_cnt;
            mem[1] = 16'h0100;
            mem[6] = 16'h0100;
            mem[12] = 16'h0100;
            run_pass(32, "stats_pass");
            check(aging_expired_cnt - e0 == 32'd6, "stats_expired", aging_expired_cnt - e0, 6);
            check(aging_pass_cnt - p0 == 32'd2, "stats_passes", aging_pass_cnt - p0, 2);
        end
`endif

        // Randomised passes: moving time, random ready, spurious acks.
        noise_en = 1;
        ready_mode = 2;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            ct_base = $urandom;
            aging_timeout = 16'($urandom);
            scan_interval = 24'($urandom_range(0, 5));
            time_run = 1;
            run_pass((it % 2 == 0) ? 16 : 32, "rand_pass");
            time_run = 0;
        end
        noise_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/classifier_flow_aging.md
Name: classifier_flow_aging

Overview:
- Background scanner downstream of the classifier flow memory.
- Periodically walks every flow expiration-time entry through the flow_etime read port and compares each stored timestamp against current time.
- Each flow idle longer than the programmed timeout produces an expired-FID request toward the flow deletion/hash-table maintenance logic.
- Sits beside the classifier lookup path; uses only the etime read port, which is otherwise idle.

Parameters:
- VALUE_DEPTH_NBITS, FLOW_VALUE_DEPTH_NBITS: flow value table address width; table holds 2^VALUE_DEPTH_NBITS entries.
- EXP_TIME_NBITS, EXP_TIME_NBITS define: stored timestamp width.
- REAL_TIME_NBITS, REAL_TIME_NBITS define: free-running time width.
- FID_NBITS, FID_NBITS define: flow ID width; must be >= VALUE_DEPTH_NBITS.
- INTERVAL_NBITS, 24: width of the scan interval counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- aging_en  in  1  scan enable, static configuration.
- aging_timeout  in  EXP_TIME_NBITS  idle limit in EXP_TIME units.
- scan_interval  in  INTERVAL_NBITS  clocks between scan passes.
- current_time  in  REAL_TIME_NBITS  free-running time.
- flow_etime_rd  out  1  one-cycle read strobe.
- flow_etime_raddr  out  VALUE_DEPTH_NBITS  read address.
- flow_etime_ack  in  1  read data valid; arrives exactly 1 cycle after rd.
- flow_etime_rdata  in  EXP_TIME_NBITS  stored timestamp.
- aging_valid  out  1  expired-flow request.
- aging_fid  out  FID_NBITS  expired flow ID; zero-extended address.
- aging_ready  in  1  consumer accepts the request.
- aging_busy  out  1  a scan pass is in progress.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; interval counter 0; address 0.
- Interval counter:
  - Counts clocks in IDLE while aging_en=1.
  - When count >= scan_interval, it clears and the FSM goes IDLE->READ.
  - aging_en=0 holds the counter at 0.
  - scan_interval=0 starts back-to-back passes.
- READ:
  - Drive flow_etime_rd=1 for exactly one cycle, with raddr = the current address.
  - Then go to WAIT.
- WAIT:
  - Hold until flow_etime_ack.
  - On ack, register rdata and now = current_time[REAL_TIME_NBITS-1 -: EXP_TIME_NBITS], then go to CMP.
- CMP (one cycle):
  - rdata==0 means an unused entry (zero-initialised): not expired.
  - Otherwise age = (now - rdata) mod 2^EXP_TIME_NBITS, an unsigned EXP_TIME_NBITS-bit subtraction, so time wrap-around is handled.
  - expired = (age > aging_timeout), strictly greater.
  - expired goes to EMIT; otherwise go to NEXT.
- EMIT:
  - aging_valid=1 with aging_fid held stable until the cycle with aging_valid&aging_ready.
  - That handshake cycle goes to NEXT.
  - aging_valid never deasserts before acceptance.
- NEXT:
  - If address == all-ones: address wraps to 0, go to IDLE, interval counter restarts.
  - Otherwise address+1, go to READ.
- aging_busy = (state != IDLE).
- aging_en deasserted mid-scan:
  - The current entry finishes, including a pending EMIT.
  - Then go to IDLE with address reset to 0.
- Throughput: at most one read every 4 cycles; no outstanding reads beyond one.
- An ack arriving outside WAIT is ignored.
- Reset mid-scan aborts immediately; an outstanding ack after reset is ignored.
- Concurrent lookup refreshes of the same entry between READ and CMP are tolerated: the comparison uses the sampled value only.

Optional Feature:
- Macro CLASSIFIER_FLOW_AGING_STATS_EN.
- When defined:
  - Adds output aging_expired_cnt [31:0], which increments by 1 on each aging_valid&aging_ready and saturates at 0xFFFFFFFF.
  - Adds output aging_pass_cnt [31:0], which increments on each completed pass (NEXT at address all-ones) and also saturates.
  - Both counters reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench configuration: VALUE_DEPTH_NBITS=4, EXP_TIME_NBITS=16, REAL_TIME_NBITS=32.
- Basic pass: all entries 0, aging_en=1, scan_interval=10 -> 16 reads at addresses 0..15, aging_valid never asserted, aging_busy falls after address 15, next pass starts 11 cycles later.
- Expiry: entry 5=0x0100, now=0x0200, timeout=0x00FF -> single aging_fid=5; with timeout=0x0100 -> none, strict compare.
- Wrap-around: entry 3=0xFFF0, now=0x0010, timeout=0x001F -> age 0x0020, aging_fid=3 emitted; timeout=0x0020 -> none.
- Backpressure: entries 2 and 9 expired, aging_ready held 0 for 20 cycles -> aging_valid=1 and aging_fid=2 stable throughout, no further reads issued; after ready, fid 9 follows.
- Disable/reset: drop aging_en during WAIT at address 7 -> entry 7 completes, FSM returns to IDLE, next pass restarts at address 0. Assert rst during EMIT -> aging_valid=0 immediately, state IDLE.
- Stats (macro on): 3 expired flows accepted over 2 passes -> aging_expired_cnt=6, aging_pass_cnt=2.
